// File: rtl/rgb_plane_packer.sv
// rgb_plane_packer: interleaved pixel stream to planar LANES-wide beats, one beat per channel,
// using two ping-pong banks so filling one group overlaps draining the other.
module rgb_plane_packer #(
  parameter int PIX_W = 8,
  parameter int LANES = 16,
  parameter int CHANNELS = 3,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  output logic [LANES*PIX_W-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW-1:0]             out_chan,
  output logic                      out_last
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int NW = $clog2(LANES + 1);
  logic [PIX_W-1:0] r_mem [2][CHANNELS][LANES];
  logic [1:0]       r_full, r_last;
  logic [NW-1:0]    r_cnt [2];
  logic [LW-1:0]    r_lane;
  logic [CW-1:0]    r_chan;
  logic             r_wr, r_rd;
  logic             w_in_acc, w_out_acc, w_grp_end, w_chan_end;
  assign in_ready   = !r_full[r_wr] && !rst;
  assign out_valid  = r_full[r_rd] && !rst;
  assign out_chan   = rst ? '0 : r_chan;
  assign w_chan_end = r_chan == CW'(CHANNELS - 1);
  assign out_last   = out_valid && r_last[r_rd] && w_chan_end;
  assign w_in_acc   = in_valid && in_ready;
  assign w_out_acc  = out_valid && out_ready;
  assign w_grp_end  = r_lane == LW'(LANES - 1) || in_last;
  // lanes beyond the recorded count belong to an older group and read as zero padding
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign out_data[(LANES-1-k)*PIX_W +: PIX_W] =
      out_valid && NW'(k) < r_cnt[r_rd] ? r_mem[r_rd][r_chan][k] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      r_last <= '0;
      r_cnt  <= '{default: '0};
      r_lane <= '0;
      r_chan <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < CHANNELS; c++)
          for (int l = 0; l < LANES; l++)
            r_mem[b][c][l] <= '0;
    end else begin
      if (w_in_acc) begin
        for (int c = 0; c < CHANNELS; c++)
          r_mem[r_wr][c][r_lane] <= in_data[c*PIX_W +: PIX_W];
        if (w_grp_end) begin
          r_full[r_wr] <= 1'b1;
          r_last[r_wr] <= in_last;
          r_cnt[r_wr]  <= NW'(r_lane) + NW'(1);
          r_lane       <= '0;
          r_wr         <= !r_wr;
        end else
          r_lane <= r_lane + LW'(1);
      end
      if (w_out_acc) begin
        if (w_chan_end) begin
          r_full[r_rd] <= 1'b0;
          r_chan       <= '0;
          r_rd         <= !r_rd;
        end else
          r_chan <= r_chan + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rgb_plane_packer.sv
// tb_rgb_plane_packer: randomized and directed checks of three packer configurations
// against a group-level reference model built from accepted pixels.
module tb_rgb_plane_packer;
  typedef struct {logic [127:0] d; int c; bit l;} beat_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int stalls [3];

  logic [23:0] a_in_data = '0;
  logic a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
  logic a_in_ready, a_out_valid, a_out_last;
  logic [127:0] a_out_data;
  logic [1:0] a_out_chan;
  logic [29:0] b_in_data = '0;
  logic b_in_valid = 0, b_in_last = 0, b_out_ready = 0, b_rand = 0;
  logic b_in_ready, b_out_valid, b_out_last;
  logic [39:0] b_out_data;
  logic [1:0] b_out_chan;
  logic [7:0] c_in_data = '0;
  logic c_in_valid = 0, c_in_last = 0, c_out_ready = 0;
  logic c_in_ready, c_out_valid, c_out_last;
  logic [7:0] c_out_data;
  logic [0:0] c_out_chan;

  rgb_plane_packer u_a (.clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_last(a_in_last), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_chan(a_out_chan), .out_last(a_out_last));
  rgb_plane_packer #(.PIX_W(10), .LANES(4), .CHANNELS(3)) u_b (.clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_chan(b_out_chan), .out_last(b_out_last));
  rgb_plane_packer #(.PIX_W(8), .LANES(1), .CHANNELS(1)) u_c (.clk(clk), .rst(rst),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_last(c_in_last),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_chan(c_out_chan), .out_last(c_out_last));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // planar beat for channel c of a group of n pixels, pixel 0 in the MSBs, missing lanes zero
  function automatic logic [127:0] beat(input logic [63:0] g [16], input int n, input int lanes,
                                        input int pw, input int c);
    logic [127:0] d = '0;
    for (int k = 0; k < n; k++)
      d |= 128'((g[k] >> (c * pw)) & ((64'd1 << pw) - 64'd1)) << ((lanes - 1 - k) * pw);
    return d;
  endfunction

  beat_t a_q[$], b_q[$], c_q[$];
  logic [63:0] a_g [16], b_g [16], c_g [16];
  int a_n = 0, b_n = 0, c_n = 0;
  int a_beats = 0, b_beats = 0, c_beats = 0, a_acc = 0, b_acc = 0, a_lastcnt = 0;
  bit c_pend = 0;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      a_q.delete();
      a_n = 0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        a_beats++;
        if (a_out_last) a_lastcnt++;
        chk("a_beat_expected", 128'(a_q.size() > 0), 128'(1));
        if (a_q.size() > 0) begin
          e = a_q.pop_front();
          chk("a_data", a_out_data, e.d);
          chk("a_chan", 128'(a_out_chan), 128'(e.c));
          chk("a_last", 128'(a_out_last), 128'(e.l));
        end
      end
      if (a_in_valid && a_in_ready) begin
        a_acc++;
        a_g[a_n] = 64'(a_in_data);
        a_n++;
        if (a_n == 16 || a_in_last) begin
          for (int c = 0; c < 3; c++) a_q.push_back('{beat(a_g, a_n, 16, 8, c), c, a_in_last && c == 2});
          a_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      b_q.delete();
      b_n = 0;
    end else begin
      if (b_out_valid && b_out_ready) begin
        b_beats++;
        chk("b_beat_expected", 128'(b_q.size() > 0), 128'(1));
        if (b_q.size() > 0) begin
          e = b_q.pop_front();
          chk("b_data", 128'(b_out_data), e.d);
          chk("b_chan", 128'(b_out_chan), 128'(e.c));
          chk("b_last", 128'(b_out_last), 128'(e.l));
        end
      end
      if (b_in_valid && b_in_ready) begin
        b_acc++;
        b_g[b_n] = 64'(b_in_data);
        b_n++;
        if (b_n == 4 || b_in_last) begin
          for (int c = 0; c < 3; c++) b_q.push_back('{beat(b_g, b_n, 4, 10, c), c, b_in_last && c == 2});
          b_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      c_q.delete();
      c_n = 0;
      c_pend = 0;
    end else begin
      if (c_pend) chk("c_latency", 128'(c_out_valid), 128'(1));
      if (c_out_valid && c_out_ready) begin
        c_beats++;
        chk("c_beat_expected", 128'(c_q.size() > 0), 128'(1));
        if (c_q.size() > 0) begin
          e = c_q.pop_front();
          chk("c_data", 128'(c_out_data), e.d);
          chk("c_chan", 128'(c_out_chan), 128'(e.c));
          chk("c_last", 128'(c_out_last), 128'(e.l));
        end
      end
      c_pend = c_in_valid && c_in_ready;
      if (c_pend) begin
        c_g[0] = 64'(c_in_data);
        c_q.push_back('{beat(c_g, 1, 1, 8, 0), 0, c_in_last});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_rand) b_out_ready = 1'($urandom % 2);
  end

  function automatic logic rdy(input int u);
    return u == 0 ? a_in_ready : u == 1 ? b_in_ready : c_in_ready;
  endfunction
  function automatic logic ovl(input int u);
    return u == 0 ? a_out_valid : u == 1 ? b_out_valid : c_out_valid;
  endfunction
  function automatic int qsz(input int u);
    return u == 0 ? a_q.size() : u == 1 ? b_q.size() : c_q.size();
  endfunction

  task automatic set_in(input int u, input logic [63:0] d, input bit l, input bit v);
    if (u == 0) begin a_in_data = d[23:0]; a_in_last = l; a_in_valid = v; end
    else if (u == 1) begin b_in_data = d[29:0]; b_in_last = l; b_in_valid = v; end
    else begin c_in_data = d[7:0]; c_in_last = l; c_in_valid = v; end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int u, input logic [63:0] d, input bit l);
    int t = 0;
    set_in(u, d, l, 1'b1);
    @(negedge clk);
    while (!rdy(u) && t < 200) begin stalls[u]++; t++; @(negedge clk); end
    if (!rdy(u)) chk("send_timeout", 128'(rdy(u)), 128'(1));
    @(posedge clk); #1;
    set_in(u, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int u);
    int t = 0;
    do begin @(negedge clk); t++; end while ((qsz(u) != 0 || ovl(u)) && t < 5000);
    chk("drain_done", 128'(qsz(u)), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int t;
    logic [127:0] h;
    bit got;
    repeat (2) @(negedge clk);
    chk("rst_a_in_ready", 128'(a_in_ready), 128'(0));
    chk("rst_b_in_ready", 128'(b_in_ready), 128'(0));
    chk("rst_c_in_ready", 128'(c_in_ready), 128'(0));
    chk("rst_a_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_a_out_data", a_out_data, 128'(0));
    chk("rst_a_out_chan", 128'(a_out_chan), 128'(0));
    chk("rst_a_out_last", 128'(a_out_last), 128'(0));
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("post_rst_a_in_ready", 128'(a_in_ready), 128'(1));
    chk("post_rst_b_in_ready", 128'(b_in_ready), 128'(1));
    chk("post_rst_c_in_ready", 128'(c_in_ready), 128'(1));
    chk("post_rst_a_out_valid", 128'(a_out_valid), 128'(0));
    @(posedge clk); #1;

    // 48 ramp pixels, out_ready high
    a_out_ready = 1; stalls[0] = 0; a_beats = 0;
    for (int j = 0; j < 48; j++) begin
      send(0, 64'({8'(j + 2), 8'(j + 1), 8'(j)}), 1'b0);
      if (j == 15) begin
        @(negedge clk);
        chk("a_lat_valid", 128'(a_out_valid), 128'(1));
        chk("a_lat_chan", 128'(a_out_chan), 128'(0));
        chk("a_first_beat", a_out_data, 128'h000102030405060708090a0b0c0d0e0f);
        @(posedge clk); #1;
      end
    end
    drain(0);
    chk("a_ramp_beats", 128'(a_beats), 128'(9));
    chk("a_ramp_stalls", 128'(stalls[0]), 128'(0));

    // frame closed on the 5th pixel, then a full group in the other bank
    a_beats = 0; a_lastcnt = 0;
    for (int j = 0; j < 5; j++) send(0, 64'($urandom), j == 4);
    t = 0;
    @(negedge clk);
    while (!a_out_valid && t < 50) begin t++; @(negedge clk); end
    chk("a_pad_chan", 128'(a_out_chan), 128'(0));
    chk("a_pad_lanes", 128'(a_out_data[87:0]), 128'(0));
    @(posedge clk); #1;
    for (int j = 0; j < 16; j++) send(0, 64'($urandom), 1'b0);
    drain(0);
    chk("a_short_beats", 128'(a_beats), 128'(6));
    chk("a_last_count", 128'(a_lastcnt), 128'(1));

    // 40-cycle output stall while 64 pixels are offered
    a_out_ready = 0; a_beats = 0; a_acc = 0; got = 0; h = '0;
    fork
      for (int j = 0; j < 64; j++) send(0, 64'($urandom), 1'b0);
      begin
        repeat (40) begin
          @(negedge clk);
          if (a_out_valid) begin
            if (!got) begin h = a_out_data; got = 1; end
            else chk("a_hold_data", a_out_data, h);
          end
        end
        chk("a_stall_accepted", 128'(a_acc), 128'(32));
        chk("a_stall_in_ready", 128'(a_in_ready), 128'(0));
        @(posedge clk); #1;
        a_out_ready = 1;
      end
    join
    drain(0);
    chk("a_stall_beats", 128'(a_beats), 128'(12));

    // reset pulsed right after the chan 1 beat is taken
    for (int j = 0; j < 16; j++) send(0, 64'($urandom), 1'b0);
    t = 0;
    @(negedge clk);
    while (!(a_out_valid && a_out_chan == 2'd1) && t < 50) begin t++; @(negedge clk); end
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("a_rst_mid_out_valid", 128'(a_out_valid), 128'(0));
    chk("a_rst_mid_in_ready", 128'(a_in_ready), 128'(1));
    @(posedge clk); #1;
    a_beats = 0;
    for (int j = 0; j < 16; j++) send(0, 64'($urandom), j == 15);
    drain(0);
    chk("a_rst_fresh_beats", 128'(a_beats), 128'(3));

    // LANES=4 CHANNELS=3 PIX_W=10, random valid/ready
    b_rand = 1; b_acc = 0;
    for (int i = 0; i < 10000; i++) begin
      repeat ($urandom % 2) begin @(posedge clk); #1; end
      send(1, 64'($urandom), ($urandom % 16) == 0);
    end
    drain(1);
    b_rand = 0;
    chk("b_accepted", 128'(b_acc), 128'(10000));

    // LANES=1 CHANNELS=1, one pixel per cycle
    c_out_ready = 1; stalls[2] = 0; c_beats = 0;
    for (int j = 0; j < 20; j++) send(2, 64'($urandom), 1'($urandom % 2));
    drain(2);
    chk("c_stalls", 128'(stalls[2]), 128'(0));
    chk("c_beats", 128'(c_beats), 128'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_plane_packer.md
# rgb_plane_packer

Parametrised front-end that converts an interleaved pixel stream (one pixel per beat, all colour channels side by side) into planar multi-pixel beats for the sobel datapath. Each group of `LANES` pixels goes out as `CHANNELS` consecutive beats, channel 0 first. This is the beat ordering the filter core consumes for 16 pixels × 3 channels. Unlike a plain feeder, the block adds:

- a valid/ready handshake on both sides,
- ping-pong buffering, so filling one group overlaps draining the previous one,
- zero-padded flushing of a partial final group,
- a channel tag and a last marker on every output beat.

## Interface
- `PIX_W`, 8, bits per channel sample
- `LANES`, 16, pixels per output beat (≥1)
- `CHANNELS`, 3, colour channels per pixel (≥1); channel 0 = red, 1 = green, 2 = blue
- `CW`, max(1,$clog2(CHANNELS)), width of `out_chan` (derived, not overridden)

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  CHANNELS*PIX_W  one pixel; channel c at `[c*PIX_W +: PIX_W]`
- `in_valid`  in  1  `in_data`/`in_last` valid
- `in_ready`  out  1  block accepts the pixel this cycle
- `in_last`  in  1  pixel closes the frame; flushes the current group
- `out_data`  out  LANES*PIX_W  one channel of one group; pixel k at `[(LANES-1-k)*PIX_W +: PIX_W]`, so pixel 0 is in the MSBs
- `out_valid`  out  1  `out_data`/`out_chan`/`out_last` valid
- `out_ready`  in  1  downstream accepts the beat
- `out_chan`  out  CW  channel index of current beat
- `out_last`  out  1  final beat (channel CHANNELS-1) of a group closed by `in_last`

## Operation
- Two banks (0/1), each holding `LANES`×`CHANNELS` samples.
  - Per-bank state: `EMPTY`/`FULL`, plus a `last` flag and a valid-pixel count.
- **Fill side:** write bank pointer `wr_bank`, lane counter `lane` (0..LANES-1).
  - `in_ready` = state[wr_bank]==EMPTY and not `rst`.
  - Accept (`in_valid && in_ready`): store the pixel at lane `lane`.
  - If `lane`==LANES-1 or `in_last`: bank → `FULL`, record `last`=in_last and count=lane+1, `lane`←0, `wr_bank` toggles.
  - Otherwise `lane`++.
- **Drain side:** read bank pointer `rd_bank`, channel counter `chan` (0..CHANNELS-1).
  - `out_valid` = state[rd_bank]==FULL.
  - `out_chan`=`chan`.
  - `out_data` lane k = stored sample (k, chan) for k < count, else 0.
  - `out_last` = last[rd_bank] && chan==CHANNELS-1.
  - Accept (`out_valid && out_ready`): if `chan`==CHANNELS-1, bank → `EMPTY`, `chan`←0 and `rd_bank` toggles; else `chan`++.
- All outputs are driven from registered state. `out_data`, `out_chan` and `out_last` hold stable while `out_valid && !out_ready`.
- `in_last` on the LANES-th pixel gives a full group with `last`=1. No extra padded group is produced.
- `in_last` when `lane`==0 (the group's first pixel) gives count=1, lanes 1..LANES-1 = 0.
- Simultaneous fill-complete and drain-complete on different banks: both take effect in the same cycle.
- A bank freed by the drain is not visible to `in_ready` until the next cycle. There is no same-cycle bypass.
- **Reset (any cycle, including mid-group or mid-drain):**
  - both banks `EMPTY` with contents, `last` and count cleared;
  - `lane`=0, `chan`=0, `wr_bank`=`rd_bank`=0;
  - partial data is discarded.
- **Output values while and after `rst`:**
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after.
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `out_last`=0.

## Timing
- **Latency:** the group-completing pixel is accepted at edge t, and `out_valid`=1 with chan 0 in the cycle after edge t.
- **Throughput:** each group takes LANES input beats and CHANNELS output beats.
  - With LANES≥CHANNELS and `out_ready` held high, `in_ready` never drops, so 1 pixel/cycle is sustained.
  - With LANES<CHANNELS the input stalls as required; no data is lost.
- **Backpressure:** with both banks `FULL`, `in_ready`=0 until the drain completes channel CHANNELS-1 of `rd_bank`.
- **Order:** groups are emitted in arrival order; the bank pointers alternate strictly.

## Test plan
- **Default parameters, 48 pixels (pixel j = {B=j+2, G=j+1, R=j}), `out_ready`=1:**
  - 9 output beats with `out_chan` 0,1,2,0,1,2,…
  - First beat = {8'd0, 8'd1, …, 8'd15}, pixel 0 in the MSBs.
  - No `in_ready` deassertion.
- **`in_last` on the 5th pixel:**
  - 3 beats with lanes 5..15 = 0.
  - `out_last`=1 only on the `out_chan`=2 beat.
  - The next frame starts in the other bank correctly.
- **`out_ready`=0 for 40 cycles while 64 pixels are offered:**
  - `in_ready` falls after 32 pixels are accepted.
  - `out_data` is stable throughout the stall.
  - After release, all 12 beats arrive in order with no loss or duplication.
- **Random `in_valid`/`out_ready` (50%), 10,000 pixels, LANES=4, CHANNELS=3, PIX_W=10:** the scoreboard matches every sample and tag.
- **`rst` pulsed mid-drain (after the chan 1 beat):**
  - the next cycle has `out_valid`=0 and `in_ready`=1;
  - the following group comes out fresh, starting at chan 0 with no stale lanes.
- **CHANNELS=1, LANES=1:**
  - `out_chan` is always 0.
  - Each pixel appears one cycle after acceptance.
  - 1 pixel/cycle is sustained.
